tt_stim_capture: RTL and testbench

On-die stimulus/response harness for Tiny Tapeout tiles, parametrised in data width, capture channel count, stimulus depth and signature width. It replays a preloaded stimulus sequence onto the tile's dedicated inputs and compresses the tile's outputs into a MISR signature. This supports self-test on silicon without cocotb, and serves as a bench-level checker. It sits between the `tt_um_*` top-level pins and the user core.

---
 rtl/tt_stim_pkg.sv | 40 ++++
 rtl/tt_misr.sv | 50 +++++
 rtl/tt_stim_capture.sv | 168 ++++++++++++++++
 tb/tb_tt_stim_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_stim_pkg.sv
// Shared types and helpers for the Tiny Tapeout stimulus/capture harness.
`timescale 1ns/1ps
package tt_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // fold() works on a fixed maximum shape; callers zero-extend into it.
    localparam int FOLD_MAX_W   = 32;
    localparam int FOLD_MAX_NCH = 8;
    localparam int FOLD_CAP_W   = FOLD_MAX_NCH * FOLD_MAX_W;

    // XOR of all enabled channels, each w bits wide, channel 0 in the LSBs.
    function automatic logic [FOLD_MAX_W-1:0] fold(
        input logic [FOLD_CAP_W-1:0]   cap,
        input logic [FOLD_MAX_NCH-1:0] mask,
        input int                      w,
        input int                      nch
    );
        logic [FOLD_MAX_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < FOLD_MAX_NCH; k++) begin
            for (int b = 0; b < FOLD_MAX_W; b++) begin
                if ((k < nch) && (b < w) && mask[k]) begin
                    acc[b] = acc[b] ^ cap[k*w + b];
                end else begin
                    acc[b] = acc[b];
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/tt_misr.sv
// Multiple-input signature register: shift-left LFSR with polynomial feedback plus parallel data fold-in.
`timescale 1ns/1ps
module tt_misr
    import tt_stim_pkg::*;
#(
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] s,
        input logic [MISR_W-1:0] d
    );
        return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? POLY : {MISR_W{1'b0}}) ^ d;
    endfunction

    // Clear wins over a capture in the same cycle.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = {MISR_W{1'b0}};
        end else if (en) begin
            sig_d = misr_step(sig_q, din);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= {MISR_W{1'b0}};
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/tt_stim_capture.sv
// Replays a preloaded stimulus sequence onto a tile's inputs and compresses its outputs into a MISR signature.
`timescale 1ns/1ps
module tt_stim_capture
    import tt_stim_pkg::*;
#(
    parameter int                W      = 8,
    parameter int                NCH    = 2,
    parameter int                DEPTH  = 16,
    parameter int                LAT    = 2,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clear,
    input  logic                   load_valid,
    input  logic [W-1:0]           load_data,
    output logic                   load_ready,
    input  logic                   start,
    output logic [W-1:0]           stim_out,
    input  logic [NCH*W-1:0]       cap_in,
    input  logic [NCH-1:0]         cap_mask,
    output logic                   busy,
    output logic                   done,
    output logic [MISR_W-1:0]      signature,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int DCW = $clog2(LAT + 2);

    state_e         state_q, state_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [W-1:0]   stim_q, stim_d;
    logic [W-1:0]   mem_q [DEPTH];

    logic              load_acc_s;
    logic              go_s;
    logic              last_s;
    logic              capture_s;
    logic              misr_clr_s;
    logic [FW-1:0]     fill_eff_s;
    logic [W-1:0]      first_word_s;
    logic [MISR_W-1:0] fold_s;

    assign load_ready = (state_q == ST_IDLE) && (fill_q < FW'(DEPTH));

    // Handshake, run-start and capture qualifiers. A load in the start cycle counts toward the run,
    // and when memory was empty that word is forwarded straight to stim_out.
    always_comb begin
        load_acc_s   = ena && !clear && load_valid && load_ready;
        fill_eff_s   = load_acc_s ? (fill_q + FW'(1)) : fill_q;
        go_s         = ena && !clear && start
                       && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                       && (fill_eff_s != '0);
        last_s       = (({1'b0, idx_q} + FW'(1)) == fill_q);
        capture_s    = ena && !clear && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        misr_clr_s   = clear || go_s;
        first_word_s = (fill_q == '0) ? load_data : mem_q[0];
        fold_s       = MISR_W'(fold(FOLD_CAP_W'(cap_in), FOLD_MAX_NCH'(cap_mask), W, NCH));
    end

    // Sequencer next-state; ena low leaves every register at its current value.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        stim_d  = stim_q;
        if (clear) begin
            state_d = ST_IDLE;
            fill_d  = '0;
            idx_d   = '0;
            drain_d = '0;
            stim_d  = '0;
        end else if (!ena) begin
            state_d = state_q;
        end else begin
            fill_d = fill_eff_s;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go_s) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        drain_d = '0;
                        stim_d  = first_word_s;
                    end else begin
                        stim_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        idx_d   = '0;
                        drain_d = '0;
                        stim_d  = '0;
                        if (LAT > 0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        idx_d  = idx_q + AW'(1);
                        stim_d = mem_q[idx_q + AW'(1)];
                    end
                end
                ST_DRAIN: begin
                    stim_d = '0;
                    if (drain_q == DCW'(LAT - 1)) begin
                        state_d = ST_DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DCW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                end
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            stim_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            stim_q  <= stim_d;
        end
    end

    // Stimulus storage; contents are meaningless while fill is zero, so no reset.
    always_ff @(posedge clk) begin
        if (load_acc_s) begin
            mem_q[fill_q[AW-1:0]] <= load_data;
        end
    end

    tt_misr #(
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture_s),
        .clr   (misr_clr_s),
        .din   (fold_s),
        .sig   (signature)
    );

    assign stim_out = stim_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign fill     = fill_q;

endmodule

// File: tb/tb_tt_stim_capture.sv
// Directed bench for tt_stim_capture: a run-level reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_tt_stim_capture;

    localparam int          W      = 8;
    localparam int          NCH    = 2;
    localparam int          DEPTH  = 16;
    localparam int          LAT    = 2;
    localparam int          MISR_W = 16;
    localparam logic [15:0] POLY   = 16'h1021;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        clear = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        start = 1'b0;
    logic [15:0] cap_in = 16'h0000;
    logic [1:0]  cap_mask = 2'b00;
    logic        load_ready, busy, done;
    logic [7:0]  stim_out;
    logic [15:0] signature;
    logic [4:0]  fill;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    tt_stim_capture #(
        .W(W), .NCH(NCH), .DEPTH(DEPTH), .LAT(LAT), .MISR_W(MISR_W), .POLY(POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .stim_out(stim_out), .cap_in(cap_in), .cap_mask(cap_mask),
        .busy(busy), .done(done), .signature(signature), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a count of captures; stim shows the word for the next capture.
    logic [7:0]  m_mem [DEPTH];
    int          m_fill;
    int          m_pos;
    bit          m_running;
    bit          m_done;
    bit          m_idle;
    logic [15:0] m_sig;
    logic [7:0]  m_stim;

    function automatic logic [15:0] m_fold(input logic [15:0] c, input logic [1:0] m);
        logic [15:0] f;
        f = 16'h0000;
        for (int k = 0; k < NCH; k++) begin
            if (m[k]) f = f ^ 16'(c[k*W +: W]);
        end
        return f;
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [15:0] f);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ POLY;
        return r ^ f;
    endfunction

    task automatic model_reset();
        m_fill = 0; m_pos = 0; m_running = 1'b0; m_done = 1'b0;
        m_sig = 16'h0000; m_stim = 8'h00;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (clear) begin
                model_reset();
            end else if (ena) begin
                m_idle = !m_running && !m_done;
                if (m_idle && load_valid && (m_fill < DEPTH)) begin
                    m_mem[m_fill] = load_data;
                    m_fill++;
                end
                if ((m_idle || m_done) && start && (m_fill > 0)) begin
                    m_running = 1'b1; m_done = 1'b0; m_pos = 0;
                    m_sig = 16'h0000; m_stim = m_mem[0];
                end else if (m_running) begin
                    m_sig = m_misr(m_sig, m_fold(cap_in, cap_mask));
                    m_pos++;
                    m_stim = (m_pos < m_fill) ? m_mem[m_pos] : 8'h00;
                    if (m_pos == m_fill + LAT) begin
                        m_running = 1'b0; m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("stim_out",   32'(stim_out),   32'(m_stim));
                check("busy",       32'(busy),       32'(m_running));
                check("done",       32'(done),       32'(m_done));
                check("signature",  32'(signature),  32'(m_sig));
                check("fill",       32'(fill),       32'(m_fill));
                check("load_ready", 32'(load_ready), 32'(!m_running && !m_done && (m_fill < DEPTH)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pat(input int k);
        if (k == 0) return 16'h0001;
        else if (k == 2) return 16'h0201;
        else return 16'h0000;
    endfunction

    task automatic wait_done(input string name, input int budget);
        for (int c = 0; c < budget && !done; c++) @(negedge clk);
        check(name, 32'(done), 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    // Run fill=4 with a capture pattern indexed by capture number, optionally stalling ena mid-RUN.
    task automatic run_pat(input bit stall_on);
        int  k;
        bit  stl;
        cap_mask = 2'b11; cap_in = 16'h0000;
        start = 1'b1; @(negedge clk); start = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            stl    = stall_on && (c >= 2) && (c < 5);
            ena    = !stl;
            cap_in = stl ? 16'hFFFF : pat(k);
            @(negedge clk);
            if (!stl) k++;
            if (stl && c == 3) begin
                check("stall_stim_hold", 32'(stim_out),  32'h33);
                check("stall_sig_hold",  32'(signature), 32'h0002);
            end
        end
        ena = 1'b1; cap_in = 16'h0000;
        check("pat_done", 32'(done),      32'd1);
        check("pat_sig",  32'(signature), 32'h0038);
    endtask

    logic [7:0] seq [4];
    int         busy_cnt;
    bit         seen17;

    initial begin
        ena = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_signature",  32'(signature),  32'h0);
        check("rst_stim_out",   32'(stim_out),   32'h0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_fill",       32'(fill),       32'd0);
        rst_n = 1'b1;

        // Load 11,22,33,44 and replay with a zero response.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 8'((i + 1) * 17); @(negedge clk);
        end
        load_valid = 1'b0;
        check("fill_4", 32'(fill), 32'd4);
        cap_mask = 2'b11; cap_in = 16'h0000; busy_cnt = 0;
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); start = 1'b0;
            if (c < 4) seq[c] = stim_out;
            if (busy) busy_cnt++;
        end
        check("seq0", 32'(seq[0]), 32'h11);
        check("seq1", 32'(seq[1]), 32'h22);
        check("seq2", 32'(seq[2]), 32'h33);
        check("seq3", 32'(seq[3]), 32'h44);
        check("busy_cycles_6", 32'(busy_cnt), 32'd6);
        check("zero_done", 32'(done), 32'd1);
        check("zero_sig", 32'(signature), 32'h0000);

        // Single impulse on channel 0 at the first capture; channel 1 junk is masked off.
        cap_mask = 2'b01; cap_in = 16'h0000;
        start = 1'b1; @(negedge clk); start = 1'b0;
        cap_in = 16'hFF01; @(negedge clk);
        cap_in = 16'hAB00;
        wait_done("impulse_done", 10);
        check("impulse_sig", 32'(signature), 32'h0020);
        cap_in = 16'h0000;

        // Same response with and without an ena stall.
        run_pat(1'b0);
        run_pat(1'b1);

        // Simultaneous load and start from empty memory.
        pulse_clear();
        check("clear_fill", 32'(fill), 32'd0);
        load_valid = 1'b1; load_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; start = 1'b0;
        check("ls_stim", 32'(stim_out), 32'h5A);
        check("ls_busy", 32'(busy), 32'd1);
        check("ls_fill", 32'(fill), 32'd1);
        wait_done("ls_done", 10);

        // Overfill: 17th word is dropped.
        pulse_clear();
        for (int i = 0; i < 17; i++) begin
            load_valid = 1'b1; load_data = 8'(8'hA0 + i); @(negedge clk);
            if (i == 15) begin
                check("full_ready_low", 32'(load_ready), 32'd0);
                check("full_fill_16",   32'(fill),       32'd16);
            end
        end
        load_valid = 1'b0;
        check("full_fill_after_17", 32'(fill), 32'd16);
        busy_cnt = 0; seen17 = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk); start = 1'b0;
            if (busy) busy_cnt++;
            if (stim_out == 8'hB0) seen17 = 1'b1;
        end
        check("full_busy_18", 32'(busy_cnt), 32'd18);
        check("full_no_17th", 32'(seen17),   32'd0);
        check("full_done",    32'(done),     32'd1);

        // Asynchronous reset during DRAIN.
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 8'(i + 1); @(negedge clk);
        end
        load_valid = 1'b0;
        cap_mask = 2'b11; cap_in = 16'h0005;
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); start = 1'b0;
        end
        check("drain_busy", 32'(busy),      32'd1);
        check("drain_sig",  32'(signature), 32'h0033);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_fill",  32'(fill),      32'd0);
        check("arst_sig",   32'(signature), 32'h0000);
        check("arst_done",  32'(done),      32'd0);
        check("arst_stim",  32'(stim_out),  32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
